// File: rtl/serial_frame_tx.sv
// Serial transmitter for the LED-matrix shift-register chain.
// Sends a captured frame MSB-first on ser_data/ser_clk, then pulses ser_latch.
module serial_frame_tx #(
  parameter int unsigned FRAME_BITS = 64,
  parameter int unsigned DIV        = 4,
  parameter int unsigned CNT_W      = 7
) (
  input  logic                  clk_main,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame_in,
  output logic                  busy,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  ser_latch,
  output logic                  done
);

  localparam int unsigned DIV_W = $clog2(DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StLatch} state_e;

  state_e                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_shl;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_end;

  assign shreg_shl = shreg << 1;
  assign div_end   = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      busy      <= 1'b0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (load) begin
            shreg    <= frame_in;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            busy     <= 1'b1;
            ser_data <= frame_in[FRAME_BITS-1];
            ser_clk  <= 1'b0;
            state    <= StLow;
          end
        end
        StLow: begin
          if (div_end) begin
            div_cnt <= '0;
            ser_clk <= 1'b1;
            state   <= StHigh;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        StHigh: begin
          if (div_end) begin
            div_cnt <= '0;
            ser_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              ser_data  <= 1'b0;
              ser_latch <= 1'b1;
              state     <= StLatch;
            end else begin
              // Next bit appears while ser_clk is low, a full half-period before its rise.
              shreg    <= shreg_shl;
              ser_data <= shreg_shl[FRAME_BITS-1];
              bit_cnt  <= bit_cnt + 1'b1;
              state    <= StLow;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        StLatch: begin
          if (div_end) begin
            div_cnt   <= '0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= StIdle;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit/DIV=1 instance for the frame
// corner cases and a default-parameter instance for full-size timing.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst;

  logic       load8;
  logic [7:0] frame8;
  logic       busy8, data8, sclk8, latch8, done8;

  logic        load64;
  logic [63:0] frame64;
  logic        busy64, data64, sclk64, latch64, done64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .FRAME_BITS(8),
    .DIV       (1),
    .CNT_W     (4)
  ) dut8 (
    .clk_main (clk),
    .reset    (rst),
    .load     (load8),
    .frame_in (frame8),
    .busy     (busy8),
    .ser_data (data8),
    .ser_clk  (sclk8),
    .ser_latch(latch8),
    .done     (done8)
  );

  serial_frame_tx dut64 (
    .clk_main (clk),
    .reset    (rst),
    .load     (load64),
    .frame_in (frame64),
    .busy     (busy64),
    .ser_data (data64),
    .ser_clk  (sclk64),
    .ser_latch(latch64),
    .done     (done64)
  );

  typedef struct {
    string      name;
    logic [7:0] frame;
    logic [7:0] frame_after;
    bit         late_load;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Observes one frame on the 8-bit instance; cycle k is sampled at the negedge after edge k.
  task automatic run_frame8(input string name, input logic [7:0] f, input logic [7:0] f_after,
                            input bit late_load, input logic [7:0] exp_bits,
                            input bit preloaded, input bit chain, input logic [7:0] chain_frame);
    logic [7:0] bits = '0;
    logic       prev_clk = 1'b0;
    int rises = 0, busy_cyc = 0, latch_cyc = 0, latch_first = 0;
    int done_cnt = 0, done_cyc = 0, busy_at1 = 0;
    if (!preloaded) begin
      @(negedge clk);
      load8  = 1'b1;
      frame8 = f;
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      load8  = 1'b0;
      frame8 = f_after;
      if (late_load && k == 5) begin
        load8  = 1'b1;
        frame8 = 8'hFF;
      end
      if (sclk8 && !prev_clk) begin
        bits = {bits[6:0], data8};
        rises++;
      end
      prev_clk = sclk8;
      if (k == 1) busy_at1 = int'(busy8);
      if (busy8) busy_cyc++;
      if (latch8) begin
        if (latch_cyc == 0) latch_first = k;
        latch_cyc++;
      end
      if (done8) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
        if (chain) begin
          load8  = 1'b1;
          frame8 = chain_frame;
          break;
        end
      end
    end
    check({name, " bits"}, bits, exp_bits);
    check({name, " rises"}, rises, 8);
    check({name, " busy_at_cycle1"}, busy_at1, 1);
    check({name, " busy_cycles"}, busy_cyc, 17);
    check({name, " latch_cycle"}, latch_first, 17);
    check({name, " latch_len"}, latch_cyc, 1);
    check({name, " done_cycle"}, done_cyc, 18);
    check({name, " done_count"}, done_cnt, 1);
  endtask

  initial begin
    vecs[0] = '{"single_a5",   8'hA5, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{"ignored_ld",  8'h00, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{"frame_chg",   8'h0F, 8'hF0, 1'b0, 8'h0F};
    vecs[3] = '{"all_ones",    8'hFF, 8'hFF, 1'b0, 8'hFF};
    vecs[4] = '{"ends_only",   8'h81, 8'h00, 1'b0, 8'h81};

    rst     = 1'b1;
    load8   = 1'b0;
    frame8  = '0;
    load64  = 1'b0;
    frame64 = '0;
    repeat (3) @(negedge clk);
    check("reset outs8", {busy8, data8, sclk8, latch8, done8}, 0);
    check("reset outs64", {busy64, data64, sclk64, latch64, done64}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-size frame at default parameters.
    begin
      logic [63:0] bits = '0;
      logic        prev_clk = 1'b0;
      int rises = 0, bad_rise = 0, hi_run = 0, bad_run = 0;
      int latch_first = 0, latch_cyc = 0, done_cyc = 0;
      @(negedge clk);
      load64  = 1'b1;
      frame64 = 64'h8000_0000_0000_0001;
      for (int k = 1; k <= 530; k++) begin
        @(negedge clk);
        load64  = 1'b0;
        frame64 = '0;
        if (sclk64 && !prev_clk) begin
          bits = {bits[62:0], data64};
          if (k != 8 * rises + 5) bad_rise++;
          rises++;
        end
        if (!sclk64 && prev_clk && hi_run != 4) bad_run++;
        hi_run   = sclk64 ? hi_run + 1 : 0;
        prev_clk = sclk64;
        if (latch64) begin
          if (latch_cyc == 0) latch_first = k;
          latch_cyc++;
        end
        if (done64 && done_cyc == 0) done_cyc = k;
      end
      check("d64 bits", bits, 64'h8000_0000_0000_0001);
      check("d64 rises", rises, 64);
      check("d64 rise_timing", bad_rise, 0);
      check("d64 high_len", bad_run, 0);
      check("d64 latch_cycle", latch_first, 513);
      check("d64 latch_len", latch_cyc, 4);
      check("d64 done_cycle", done_cyc, 517);
    end

    foreach (vecs[i])
      run_frame8(vecs[i].name, vecs[i].frame, vecs[i].frame_after, vecs[i].late_load,
                 vecs[i].exp_bits, 1'b0, 1'b0, 8'h00);

    // Load in the done cycle starts the next frame with no gap.
    run_frame8("b2b_first", 8'h5A, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h3C);
    run_frame8("b2b_second", 8'h3C, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00);

    // Reset while bit 3 is being clocked out.
    begin
      int stray = 0;
      @(negedge clk);
      load8  = 1'b1;
      frame8 = 8'hFF;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        load8 = 1'b0;
      end
      check("midrst pre_clk", {busy8, sclk8, data8}, 3'b111);
      #2 rst = 1'b1;
      #1 check("midrst outs", {busy8, data8, sclk8, latch8, done8}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (latch8 || busy8 || done8 || sclk8) stray++;
      end
      check("midrst quiet", stray, 0);
    end
    run_frame8("after_rst", 8'hC3, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Single-clock serial transmitter that drives the LED-matrix shift-register chain. It captures a parallel board frame on a load strobe and shifts it out MSB-first as data, clock and latch lines. The serial clock comes from a clock-enable divider, not a derived clock. It sits between the game-state logic (snake body/head/food bitmap) and the external display driver.

Parameters:
FRAME_BITS, 64, number of bits per frame (8x8 board); minimum 2
DIV, 4, clk_main cycles per serial half-period; minimum 1
CNT_W, 7, width of the bit counter; must satisfy 2^CNT_W > FRAME_BITS

Ports:
clk_main  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  single-cycle request to transmit frame_in; sampled only in IDLE
frame_in  input  FRAME_BITS  parallel frame; bit FRAME_BITS-1 is sent first
busy  output  1  high from the cycle after an accepted load until return to IDLE
ser_data  output  1  serial data to the display chain
ser_clk  output  1  serial shift clock; the display samples on its rising edge
ser_latch  output  1  high for DIV cycles after the last bit; transfers data to the outputs
done  output  1  one-cycle pulse on entry to IDLE after a completed frame

Behaviour:
- Reset (async, any state): state=IDLE; shift reg, bit counter and divider counter =0; busy=0, ser_data=0, ser_clk=0, ser_latch=0, done=0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, LOW, HIGH, LATCH.
- IDLE: ser_clk=0, ser_latch=0, busy=0. If load=1 at edge N, then frame_in goes to the shift reg, bit_cnt=0, div_cnt=0, and the next state is LOW. At cycle N+1: busy=1, ser_data=frame_in[FRAME_BITS-1].
- LOW: ser_clk=0 and ser_data=shreg MSB, held for DIV cycles. At the end of the DIV cycles, go to HIGH.
- HIGH: ser_clk=1 for DIV cycles, and ser_data stays stable. At the end of the DIV cycles:
  - If bit_cnt==FRAME_BITS-1: go to LATCH, with ser_clk=0 and ser_data=0.
  - Otherwise: shift the shift reg left by 1 (fill 0), bit_cnt+1, and go to LOW.
- LATCH: ser_latch=1 for DIV cycles, ser_clk=0. At the end, go to IDLE, with busy=0 and done=1 for exactly one cycle.
- div_cnt counts 0..DIV-1, wraps to 0 on each state change, and is never left in an intermediate value across states.
- Frame duration: from load edge to the done-high cycle is exactly 2*DIV*FRAME_BITS + DIV + 1 cycles. With defaults: 517.
- Exactly FRAME_BITS rising edges of ser_clk per frame. ser_data changes only while ser_clk=0, at LOW entry.
- load while busy=1 is ignored; no queueing. The frame being sent is unaffected by frame_in changes after capture.
- load asserted in the same cycle done=1 (state is IDLE) is accepted, giving back-to-back frames with no extra gap.
- Reset mid-frame aborts at once. All outputs go to 0 and no latch pulse is issued, so the display keeps its previous frame.
- Counter widths: bit_cnt is CNT_W bits and the compare uses FRAME_BITS-1. The divider counter width is $clog2(DIV)+1. No overflow is possible within legal parameters.

Test Plan:
- Reset mid-frame → outputs: FRAME_BITS=8, DIV=1. Assert reset during bit 3 → all outputs 0 in the same cycle, before the next edge; no ser_latch pulse; next load starts a fresh frame.
- Single frame: FRAME_BITS=8, DIV=1, frame_in=8'hA5, load pulse at cycle 0.
  - ser_data sampled at ser_clk rises = 1,0,1,0,0,1,0,1.
  - 8 rising edges; ser_latch high at cycle 17.
  - done at cycle 18; busy high during cycles 1..17.
- Timing at defaults: FRAME_BITS=64, DIV=4, frame_in=64'h8000_0000_0000_0001 → ser_clk high for 4 cycles and low for 4 cycles per bit; first and last sampled bits =1, all others 0; done 517 cycles after load.
- Ignored load: FRAME_BITS=8, DIV=1. Second load with frame_in=8'hFF at cycle 5 of an 8'h00 frame → all 8 sampled bits 0; exactly one done pulse.
- Back-to-back: load asserted in the done cycle with 8'h3C → second frame starts immediately; busy low for exactly that one cycle; bits 0,0,1,1,1,1,0,0.
- Frame_in change after capture: frame_in switched from 8'h0F to 8'hF0 one cycle after load → transmitted bits remain 0,0,0,0,1,1,1,1.
